// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode constants and instruction-field decode for the ID stage
package mips_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [RW_DEF-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic              uses_rs;
        logic              uses_rt;
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              zext;
        logic [RW_DEF-1:0] wn;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op,
                                    input logic [RW_DEF-1:0] rt,
                                    input logic [RW_DEF-1:0] rd);
        dec_t d;
        d = '0;
        case (op)
            OP_RTYPE: begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.wreg = 1'b1; d.wn = rd; end
            OP_ADDI:  begin d.uses_rs = 1'b1; d.wreg = 1'b1; d.wn = rt; end
            OP_ANDI, OP_ORI, OP_XORI:
                      begin d.uses_rs = 1'b1; d.wreg = 1'b1; d.wn = rt; d.zext = 1'b1; end
            OP_LUI:   begin d.wreg = 1'b1; d.wn = rt; end
            OP_LW:    begin d.uses_rs = 1'b1; d.wreg = 1'b1; d.m2reg = 1'b1; d.wn = rt; end
            OP_SW:    begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.wmem = 1'b1; end
            OP_BEQ, OP_BNE:
                      begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; end
            OP_JAL:   begin d.wreg = 1'b1; d.wn = REG_RA; end
            default:  ;
        endcase
        // r0 is hardwired, so a write to it is never a real write
        if (d.wn == '0) d.wreg = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// rtl/id_operand_stage_if.sv - regfile read port and ID/EX register bundle
interface id_operand_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic [RW-1:0] rna;
    logic [RW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic          e_valid;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
    logic [DW-1:0] e_imm;
    logic [RW-1:0] e_wn;
    logic          e_wreg;
    logic          e_m2reg;
    logic          e_wmem;
    logic [5:0]    e_op;
    logic [5:0]    e_funct;
    logic [4:0]    e_shamt;

    modport master (
        output rna, rnb, e_valid, e_a, e_b, e_imm, e_wn,
               e_wreg, e_m2reg, e_wmem, e_op, e_funct, e_shamt,
        input  qa, qb
    );

    modport slave (
        input  rna, rnb, e_valid, e_a, e_b, e_imm, e_wn,
               e_wreg, e_m2reg, e_wmem, e_op, e_funct, e_shamt,
        output qa, qb
    );
endinterface

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - priority forwarding of one source operand from EX/MEM/WB
module fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [RW-1:0] x_wn,
    input  logic          x_wreg,
    input  logic          x_m2reg,
    input  logic [DW-1:0] x_alu,
    input  logic [RW-1:0] m_wn,
    input  logic          m_wreg,
    input  logic          m_m2reg,
    input  logic [DW-1:0] m_alu,
    input  logic [DW-1:0] m_mdata,
    input  logic [RW-1:0] w_wn,
    input  logic          w_we,
    input  logic [DW-1:0] w_data,
    input  logic [DW-1:0] q,
    output logic [DW-1:0] y
);
    // a load still in EX has no data yet; the hazard stall covers that case
    always_comb begin
        y = q;
        if (src == '0)
            y = '0;
        else if (x_wreg && !x_m2reg && x_wn == src)
            y = x_alu;
        else if (m_wreg && m_wn == src)
            y = m_m2reg ? m_mdata : m_alu;
        else if (w_we && w_wn == src)
            y = w_data;
    end
endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - MIPS decode/operand fetch with forwarding, load-use stall and ID/EX register
module id_operand_stage
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          d_valid,
    input  logic [31:0]   d_inst,
    input  logic          flush,
    input  logic [RW-1:0] x_wn,
    input  logic          x_wreg,
    input  logic          x_m2reg,
    input  logic [DW-1:0] x_alu,
    input  logic [RW-1:0] m_wn,
    input  logic          m_wreg,
    input  logic          m_m2reg,
    input  logic [DW-1:0] m_alu,
    input  logic [DW-1:0] m_mdata,
    input  logic [RW-1:0] w_wn,
    input  logic          w_we,
    input  logic [DW-1:0] w_data,
    output logic          stall,
    id_operand_stage_if.master bus
);
    logic [RW-1:0] rs, rt;
    logic [DW-1:0] fwd_a, fwd_b, imm_ext;
    logic          hazard, bubble;
    dec_t          dec;

    assign rs      = d_inst[25:21];
    assign rt      = d_inst[20:16];
    assign bus.rna = rs;
    assign bus.rnb = rt;
    assign dec     = decode(d_inst[31:26], d_inst[20:16], d_inst[15:11]);
    assign imm_ext = dec.zext ? {{(DW-16){1'b0}}, d_inst[15:0]}
                              : {{(DW-16){d_inst[15]}}, d_inst[15:0]};

    assign hazard = d_valid && x_wreg && x_m2reg && (x_wn != '0) &&
                    ((dec.uses_rs && rs == x_wn) || (dec.uses_rt && rt == x_wn));
    assign stall  = hazard && !flush;
    assign bubble = flush || stall || !d_valid;

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .src(rs), .x_wn(x_wn), .x_wreg(x_wreg), .x_m2reg(x_m2reg), .x_alu(x_alu),
        .m_wn(m_wn), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_alu(m_alu), .m_mdata(m_mdata),
        .w_wn(w_wn), .w_we(w_we), .w_data(w_data), .q(bus.qa), .y(fwd_a)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .src(rt), .x_wn(x_wn), .x_wreg(x_wreg), .x_m2reg(x_m2reg), .x_alu(x_alu),
        .m_wn(m_wn), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_alu(m_alu), .m_mdata(m_mdata),
        .w_wn(w_wn), .w_we(w_we), .w_data(w_data), .q(bus.qb), .y(fwd_b)
    );

    // data fields load unconditionally; a bubble only needs its controls cleared
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bus.e_valid <= 1'b0;
            bus.e_wreg  <= 1'b0;
            bus.e_m2reg <= 1'b0;
            bus.e_wmem  <= 1'b0;
            bus.e_a     <= '0;
            bus.e_b     <= '0;
            bus.e_imm   <= '0;
            bus.e_wn    <= '0;
            bus.e_op    <= '0;
            bus.e_funct <= '0;
            bus.e_shamt <= '0;
        end else begin
            bus.e_valid <= !bubble;
            bus.e_wreg  <= !bubble && dec.wreg;
            bus.e_m2reg <= !bubble && dec.m2reg;
            bus.e_wmem  <= !bubble && dec.wmem;
            bus.e_a     <= fwd_a;
            bus.e_b     <= fwd_b;
            bus.e_imm   <= imm_ext;
            bus.e_wn    <= dec.wn;
            bus.e_op    <= d_inst[31:26];
            bus.e_funct <= d_inst[5:0];
            bus.e_shamt <= d_inst[10:6];
        end
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - directed vector bench for id_operand_stage
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        d_valid, flush, stall;
    logic [31:0] d_inst;
    logic [4:0]  x_wn, m_wn, w_wn;
    logic        x_wreg, x_m2reg, m_wreg, m_m2reg, w_we;
    logic [31:0] x_alu, m_alu, m_mdata, w_data;

    id_operand_stage_if #(.DW(32), .RW(5)) bus ();

    id_operand_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .clrn(clrn), .d_valid(d_valid), .d_inst(d_inst), .flush(flush),
        .x_wn(x_wn), .x_wreg(x_wreg), .x_m2reg(x_m2reg), .x_alu(x_alu),
        .m_wn(m_wn), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_alu(m_alu), .m_mdata(m_mdata),
        .w_wn(w_wn), .w_we(w_we), .w_data(w_data), .stall(stall), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] inst;
        logic        fl;
        logic [31:0] qa, qb;
        logic [4:0]  xwn;
        logic        xwe, xm2;
        logic [31:0] xalu;
        logic [4:0]  mwn;
        logic        mwe, mm2;
        logic [31:0] malu, mdat;
        logic [4:0]  wwn;
        logic        wwe;
        logic [31:0] wdat;
        logic        stall, ev, ewreg, em2, ewmem, chk;
        logic [31:0] ea, eb, eimm;
        logic [4:0]  ewn;
    } vec_t;

    vec_t vecs[$];
    vec_t t;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur   = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %h expected %h", cur, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        d_valid = v.v;    d_inst  = v.inst; flush   = v.fl;
        bus.qa  = v.qa;   bus.qb  = v.qb;
        x_wn    = v.xwn;  x_wreg  = v.xwe;  x_m2reg = v.xm2; x_alu = v.xalu;
        m_wn    = v.mwn;  m_wreg  = v.mwe;  m_m2reg = v.mm2; m_alu = v.malu; m_mdata = v.mdat;
        w_wn    = v.wwn;  w_we    = v.wwe;  w_data  = v.wdat;
    endtask

    initial begin
        // add r3,r1,r2 with no forwarding
        t = '0; t.v = 1; t.inst = 32'h00221820; t.qa = 32'hA00000AA; t.qb = 32'h10000011;
        t.ev = 1; t.ewreg = 1; t.chk = 1; t.ea = 32'hA00000AA; t.eb = 32'h10000011;
        t.eimm = 32'h00001820; t.ewn = 3; vecs.push_back(t);
        // add r4,r1,r1: EX beats MEM
        t = '0; t.v = 1; t.inst = 32'h00212020; t.qa = 32'h1; t.qb = 32'h2;
        t.xwn = 1; t.xwe = 1; t.xalu = 32'h12345678; t.mwn = 1; t.mwe = 1; t.malu = 32'hDEAD0000;
        t.ev = 1; t.ewreg = 1; t.chk = 1; t.ea = 32'h12345678; t.eb = 32'h12345678;
        t.eimm = 32'h00002020; t.ewn = 4; vecs.push_back(t);
        // add r6,r5,r0 behind lw r5: stall and bubble
        t = '0; t.v = 1; t.inst = 32'h00A03020; t.xwn = 5; t.xwe = 1; t.xm2 = 1;
        t.stall = 1; vecs.push_back(t);
        // same instruction next cycle, load now in MEM
        t = '0; t.v = 1; t.inst = 32'h00A03020; t.qa = 32'hBADBAD00; t.qb = 32'h77;
        t.mwn = 5; t.mwe = 1; t.mm2 = 1; t.malu = 32'h5; t.mdat = 32'h40000044;
        t.ev = 1; t.ewreg = 1; t.chk = 1; t.ea = 32'h40000044; t.eb = 32'h0;
        t.eimm = 32'h00003020; t.ewn = 6; vecs.push_back(t);
        // addi r9,r8,-1 with WB bypass
        t = '0; t.v = 1; t.inst = 32'h2109FFFF; t.qa = 32'hFFFFFFFF; t.qb = 32'h77;
        t.wwn = 8; t.wwe = 1; t.wdat = 32'h00000002;
        t.ev = 1; t.ewreg = 1; t.chk = 1; t.ea = 32'h2; t.eb = 32'h77;
        t.eimm = 32'hFFFFFFFF; t.ewn = 9; vecs.push_back(t);
        // load-use plus flush: flush wins
        t = '0; t.v = 1; t.inst = 32'h00A03020; t.fl = 1; t.xwn = 5; t.xwe = 1; t.xm2 = 1;
        vecs.push_back(t);
        // add r7,r0,r2 with x writing r0
        t = '0; t.v = 1; t.inst = 32'h00023820; t.qa = 32'h99; t.qb = 32'h22;
        t.xwn = 0; t.xwe = 1; t.xalu = 32'h55;
        t.ev = 1; t.ewreg = 1; t.chk = 1; t.ea = 32'h0; t.eb = 32'h22;
        t.eimm = 32'h00003820; t.ewn = 7; vecs.push_back(t);
        // ori r2,r0,0x8000 zero-extends
        t = '0; t.v = 1; t.inst = 32'h34028000; t.qa = 32'h99; t.qb = 32'h33;
        t.ev = 1; t.ewreg = 1; t.chk = 1; t.ea = 32'h0; t.eb = 32'h33;
        t.eimm = 32'h00008000; t.ewn = 2; vecs.push_back(t);
        // lw r10,4(r1)
        t = '0; t.v = 1; t.inst = 32'h8C2A0004; t.qa = 32'h100; t.qb = 32'h44;
        t.ev = 1; t.ewreg = 1; t.em2 = 1; t.chk = 1; t.ea = 32'h100; t.eb = 32'h44;
        t.eimm = 32'h4; t.ewn = 10; vecs.push_back(t);
        // sw r10,-8(r1), store data from MEM ALU result
        t = '0; t.v = 1; t.inst = 32'hAC2AFFF8; t.qa = 32'h200; t.qb = 32'h1;
        t.mwn = 10; t.mwe = 1; t.malu = 32'hCAFE; t.mdat = 32'hBEEF;
        t.ev = 1; t.ewmem = 1; t.chk = 1; t.ea = 32'h200; t.eb = 32'hCAFE;
        t.eimm = 32'hFFFFFFF8; t.ewn = 0; vecs.push_back(t);
        // invalid slot
        t = '0; t.v = 0; t.inst = 32'h00221820; vecs.push_back(t);
        // jal writes r31
        t = '0; t.v = 1; t.inst = 32'h0C000010;
        t.ev = 1; t.ewreg = 1; t.chk = 1; t.eimm = 32'h10; t.ewn = 31; vecs.push_back(t);
        // add r0,r1,r2: write to r0 suppressed
        t = '0; t.v = 1; t.inst = 32'h00220020; t.qa = 32'h5; t.qb = 32'h6;
        t.ev = 1; t.chk = 1; t.ea = 32'h5; t.eb = 32'h6; t.eimm = 32'h20; t.ewn = 0;
        vecs.push_back(t);
        // unknown opcode behaves as NOP
        t = '0; t.v = 1; t.inst = 32'hFC000000; t.ev = 1; vecs.push_back(t);
        // beq r5,r6 behind lw r6: hazard on rt
        t = '0; t.v = 1; t.inst = 32'h10A60000; t.xwn = 6; t.xwe = 1; t.xm2 = 1;
        t.stall = 1; vecs.push_back(t);
        // lui r3 with rs field matching a load: no stall
        t = '0; t.v = 1; t.inst = 32'h3CA31234; t.qa = 32'h11; t.qb = 32'h12;
        t.xwn = 5; t.xwe = 1; t.xm2 = 1;
        t.ev = 1; t.ewreg = 1; t.chk = 1; t.ea = 32'h11; t.eb = 32'h12;
        t.eimm = 32'h1234; t.ewn = 3; vecs.push_back(t);
        // flush alone squashes a valid instruction
        t = '0; t.v = 1; t.inst = 32'h00221820; t.fl = 1; vecs.push_back(t);

        t = '0;
        drive(t);
        clrn = 1'b0;
        #12;
        chk("reset e_valid", {31'b0, bus.e_valid}, 32'h0);
        chk("reset e_wreg",  {31'b0, bus.e_wreg},  32'h0);
        chk("reset e_a",     bus.e_a,               32'h0);
        chk("reset e_wn",    {27'b0, bus.e_wn},     32'h0);
        clrn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            t = vecs[i];
            @(negedge clk);
            drive(t);
            #1;
            chk("stall", {31'b0, stall},      {31'b0, t.stall});
            chk("rna",   {27'b0, bus.rna},    {27'b0, t.inst[25:21]});
            chk("rnb",   {27'b0, bus.rnb},    {27'b0, t.inst[20:16]});
            @(posedge clk);
            #1;
            chk("e_valid", {31'b0, bus.e_valid}, {31'b0, t.ev});
            chk("e_wreg",  {31'b0, bus.e_wreg},  {31'b0, t.ewreg});
            chk("e_m2reg", {31'b0, bus.e_m2reg}, {31'b0, t.em2});
            chk("e_wmem",  {31'b0, bus.e_wmem},  {31'b0, t.ewmem});
            if (t.chk) begin
                chk("e_a",     bus.e_a,               t.ea);
                chk("e_b",     bus.e_b,               t.eb);
                chk("e_imm",   bus.e_imm,             t.eimm);
                chk("e_wn",    {27'b0, bus.e_wn},     {27'b0, t.ewn});
                chk("e_op",    {26'b0, bus.e_op},     {26'b0, t.inst[31:26]});
                chk("e_funct", {26'b0, bus.e_funct},  {26'b0, t.inst[5:0]});
                chk("e_shamt", {27'b0, bus.e_shamt},  {27'b0, t.inst[10:6]});
            end
        end

        // asynchronous reset while a stall is pending
        cur = 100;
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk);
        #1;
        chk("pre-reset e_valid", {31'b0, bus.e_valid}, 32'h1);
        @(negedge clk);
        drive(vecs[2]);
        #1;
        chk("pre-reset stall", {31'b0, stall}, 32'h1);
        clrn = 1'b0;
        #1;
        chk("async e_valid", {31'b0, bus.e_valid}, 32'h0);
        chk("async e_wreg",  {31'b0, bus.e_wreg},  32'h0);
        chk("async e_a",     bus.e_a,               32'h0);
        chk("async stall",   {31'b0, stall},        32'h1);
        @(negedge clk);
        clrn = 1'b1;
        t = '0;
        drive(t);
        @(posedge clk);
        #1;
        chk("post-reset e_valid", {31'b0, bus.e_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
Decode/operand-fetch stage of the 5-stage MIPS pipeline. It sits directly downstream of the 32x32 register file: it drives the regfile read addresses and consumes the qa/qb read data. It also decodes the register-usage fields, forwards results from the EX, MEM and WB stages, detects load-use hazards and stalls for them, and holds the ID/EX pipeline register that feeds the ALU stage.

Parameters:
DW, 32, datapath width
RW, 5, register-number width

Ports:
clk  in  1  clock, posedge
clrn  in  1  reset, asynchronous, active-low
d_valid  in  1  IF/ID register holds a valid instruction
d_inst  in  32  IF/ID instruction word
flush  in  1  branch/jump taken; squash the instruction in ID
rna  out  RW  regfile read port A address (= inst[25:21])
rnb  out  RW  regfile read port B address (= inst[20:16])
qa  in  DW  regfile read data A
qb  in  DW  regfile read data B
x_wn, x_wreg, x_m2reg, x_alu  in  RW,1,1,DW  EX-stage dest, write enable, is-load, ALU result
m_wn, m_wreg, m_m2reg, m_alu, m_mdata  in  RW,1,1,DW,DW  MEM-stage dest, write enable, is-load, ALU result, load data
w_wn, w_we, w_data  in  RW,1,DW  WB-stage regfile write port (same signals as the regfile's wn/we/data)
stall  out  1  hold PC and IF/ID this cycle
e_valid  out  1  ID/EX valid
e_a, e_b  out  DW  forwarded operands
e_imm  out  DW  extended immediate
e_wn  out  RW  destination register
e_wreg, e_m2reg, e_wmem  out  1  write-reg, load, store controls
e_op, e_funct  out  6  opcode and funct fields
e_shamt  out  5  shift amount

Behaviour:
- rna/rnb are driven combinationally from d_inst, every cycle, regardless of d_valid.
- Decode (combinational):
  - op=0x00 R-type: uses rs and rt; writes rd.
  - 0x08 addi, 0x0C andi, 0x0D ori, 0x0E xori: use rs; write rt.
  - 0x0F lui: uses neither rs nor rt; writes rt.
  - 0x23 lw: uses rs; writes rt; m2reg=1.
  - 0x2B sw: uses rs and rt; wmem=1; no register write.
  - 0x04 beq, 0x05 bne: use rs and rt; no register write.
  - 0x02 j: no register use, no write.
  - 0x03 jal: writes r31.
  - Any other opcode: treated as a NOP (wreg=0, wmem=0, uses none).
  - Destination r0 forces wreg=0.
- Immediate extension: zero-extended for andi/ori/xori; sign-extended otherwise.
- Operand forwarding, evaluated per source register (rs→e_a, rt→e_b), highest priority first:
  - Source register is 0: operand is 0.
  - x_wreg && !x_m2reg && x_wn==src: x_alu.
  - m_wreg && m_wn==src: m_mdata if m_m2reg, else m_alu.
  - w_we && w_wn==src: w_data. The regfile updates on the same edge, so the ID read would otherwise be stale.
  - Otherwise: qa/qb.
- Load-use hazard: asserted when d_valid && x_wreg && x_m2reg && x_wn!=0 && ((uses_rs && rs==x_wn) || (uses_rt && rt==x_wn)).
  - stall=1 for exactly that cycle.
  - At the next edge the ID/EX register takes a bubble.
  - The next cycle the load has reached MEM and resolves via m_mdata.
- stall is combinational: hazard && !flush.
- ID/EX update at posedge clk:
  - flush || stall || !d_valid: bubble. e_valid=0, e_wreg=0, e_m2reg=0, e_wmem=0. The data fields may hold don't-care values; the bench checks only the control fields.
  - Otherwise: load all decoded and forwarded fields; e_valid=1.
- flush and hazard in the same cycle: flush wins; stall=0 and a bubble is inserted.
- Reset (clrn=0, asynchronous): every e_* output = 0, which forms a bubble. stall follows its inputs combinationally. Reset asserted mid-stall clears the pipeline register immediately.
- Latency: one cycle from the ID inputs to the e_* outputs.

Decomposition:
- Package mips_pkg:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL)
  - REG_RA=31
  - DW/RW defaults
- Sub-module fwd_mux: one per operand. Inputs are src, the x/m/w triples and the regfile data; output is the forwarded value. Instantiated twice.

Test Plan:
- Reset, then add r3,r1,r2 with qa=0xA00000AA, qb=0x10000011 and no forwarding → one cycle later e_valid=1, e_a=0xA00000AA, e_b=0x10000011, e_wn=3, e_wreg=1.
- x_wn=1, x_wreg=1, x_alu=0x12345678, m_wn=1, m_alu=0xDEAD0000, then add r4,r1,r1 → e_a=e_b=0x12345678 (EX beats MEM).
- x_wn=5, x_m2reg=1, x_wreg=1, ID holds add r6,r5,r0 → stall=1 and e_valid=0 next cycle. Next cycle m_wn=5, m_m2reg=1, m_mdata=0x40000044, stall=0 → e_a=0x40000044.
- w_we=1, w_wn=8, w_data=0x00000002, qa stale=0xFFFFFFFF, ID holds addi r9,r8,-1 → e_a=0x00000002, e_imm=0xFFFFFFFF, e_wn=9.
- Load-use condition plus flush=1 in the same cycle → stall=0, e_valid=0, e_wreg=0.
- Source r0 with x_wn=0, x_wreg=1, x_alu=0x55 → e_a=0. Separately, ori r2,r0,0x8000 → e_imm=0x00008000.
